// File: rtl/decode_ctrl_if.sv
// decode_ctrl_if: D-stage instruction in, decode status and ID/EX control register out
//   master: pipeline side, drives InstrD/ValidD/FlushE and observes the controls
//   slave : decode_ctrl_stage, drives ImmSrcD, IllegalD, the E-stage controls, DivStartE, StallReq
interface decode_ctrl_if #(
    parameter int ALUC_W = 5
);
    logic [31:0]       InstrD;
    logic              ValidD;
    logic              FlushE;
    logic [2:0]        ImmSrcD;
    logic              IllegalD;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              ALUSrcE;
    logic              BranchE;
    logic              JumpE;
    logic              JalrE;
    logic [1:0]        ResultSrcE;
    logic [ALUC_W-1:0] ALUControlE;
    logic [2:0]        Funct3E;
    logic              DivStartE;
    logic              StallReq;
    modport master (
        output InstrD, ValidD, FlushE,
        input  ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE,
               ResultSrcE, ALUControlE, Funct3E, DivStartE, StallReq
    );
    modport slave (
        input  InstrD, ValidD, FlushE,
        output ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE,
               ResultSrcE, ALUControlE, Funct3E, DivStartE, StallReq
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: RV32I(+M) decoder, ID/EX control register and multi-cycle divide sequencer
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : decode_ctrl_if.slave (instruction in, decode status, E-stage controls, DivStartE, StallReq)
module decode_ctrl_stage #(
    parameter int M_EXT      = 1,
    parameter int DIV_CYCLES = 8,
    parameter int ALUC_W     = 5
) (
    input logic          clk,
    input logic          rst,
    decode_ctrl_if.slave bus
);
    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [ALUC_W-1:0] A_ADD = ALUC_W'(5'b00000);
    localparam logic [ALUC_W-1:0] A_SUB = ALUC_W'(5'b00001);
    localparam logic [ALUC_W-1:0] A_MUL = ALUC_W'(5'b00010);
    localparam logic [ALUC_W-1:0] A_DIV = ALUC_W'(5'b00011);
    localparam logic [ALUC_W-1:0] A_SLL = ALUC_W'(5'b00100);
    localparam logic [ALUC_W-1:0] A_SRL = ALUC_W'(5'b00101);
    localparam logic [ALUC_W-1:0] A_REM = ALUC_W'(5'b00110);
    localparam logic [ALUC_W-1:0] A_SLT = ALUC_W'(5'b00111);
    localparam logic [ALUC_W-1:0] A_AND = ALUC_W'(5'b01000);
    localparam logic [ALUC_W-1:0] A_OR  = ALUC_W'(5'b01001);
    localparam logic [ALUC_W-1:0] A_XOR = ALUC_W'(5'b01010);
    localparam logic [ALUC_W-1:0] A_PB  = ALUC_W'(5'b10000);

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              alu_src;
        logic              branch;
        logic              jump;
        logic              jalr;
        logic [1:0]        result_src;
        logic [ALUC_W-1:0] alu_ctrl;
        logic [2:0]        funct3;
    } ctrl_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // slt and sltu share one code; the ALU tells them apart by Funct3E
    function automatic logic [ALUC_W-1:0] alu_f3(input logic [2:0] f);
        return f == 3'b000 ? A_ADD : f == 3'b001 ? A_SLL : f[2:1] == 2'b01 ? A_SLT :
               f == 3'b100 ? A_XOR : f == 3'b101 ? A_SRL : f == 3'b110 ? A_OR : A_AND;
    endfunction

    logic [6:0] op, f7;
    logic [2:0] f3, imm;
    logic       ok, live;
    ctrl_t      raw, dec, e;
    state_t     state;
    logic [CW-1:0] cnt;
    logic       is_div;
    logic       unused;

    assign op     = bus.InstrD[6:0];
    assign f3     = bus.InstrD[14:12];
    assign f7     = bus.InstrD[31:25];
    assign unused = ^{bus.InstrD[24:15], bus.InstrD[11:7]};

    always_comb begin
        ok  = 1'b0;
        imm = 3'b000;
        raw = '0;
        raw.funct3 = f3;
        case (op)
            7'b0000011: begin
                ok = f3 != 3'b011 && f3[2:1] != 2'b11;
                raw.reg_write  = 1'b1;
                raw.alu_src    = 1'b1;
                raw.result_src = 2'b01;
            end
            7'b0100011: begin
                ok  = f3 < 3'b011;
                imm = 3'b001;
                raw.mem_write = 1'b1;
                raw.alu_src   = 1'b1;
            end
            7'b0110011: begin
                raw.reg_write = 1'b1;
                if (f7 == 7'b0000000) begin
                    ok = 1'b1;
                    raw.alu_ctrl = alu_f3(f3);
                end else if (f7 == 7'b0100000) begin
                    ok = f3 == 3'b000;
                    raw.alu_ctrl = A_SUB;
                end else if (f7 == 7'b0000001 && M_EXT != 0) begin
                    // mulh* are not supported; div/divu and rem/remu share codes
                    ok = f3 == 3'b000 || f3[2];
                    raw.alu_ctrl = !f3[2] ? A_MUL : f3[1] ? A_REM : A_DIV;
                end
            end
            7'b0010011: begin
                // funct7 only matters for shifts; srai is not supported
                ok = f3[1:0] != 2'b01 || f7 == 7'b0000000;
                raw.reg_write = 1'b1;
                raw.alu_src   = 1'b1;
                raw.alu_ctrl  = alu_f3(f3);
            end
            7'b1100011: begin
                ok  = f3[2:1] != 2'b01;
                imm = 3'b010;
                raw.branch   = 1'b1;
                raw.alu_ctrl = A_SUB;
            end
            7'b1101111: begin
                ok  = 1'b1;
                imm = 3'b011;
                raw.reg_write  = 1'b1;
                raw.jump       = 1'b1;
                raw.result_src = 2'b10;
            end
            7'b1100111: begin
                ok = f3 == 3'b000;
                raw.reg_write  = 1'b1;
                raw.jalr       = 1'b1;
                raw.alu_src    = 1'b1;
                raw.result_src = 2'b10;
            end
            7'b0110111: begin
                ok  = 1'b1;
                imm = 3'b100;
                raw.reg_write = 1'b1;
                raw.alu_src   = 1'b1;
                raw.alu_ctrl  = A_PB;
            end
            default: ok = 1'b0;
        endcase
    end

    assign live         = bus.ValidD & ok;
    assign dec          = live ? raw : '0;
    assign bus.ImmSrcD  = live ? imm : 3'b000;
    assign bus.IllegalD = bus.ValidD & ~ok;

    assign is_div        = e.reg_write & (e.alu_ctrl == A_DIV | e.alu_ctrl == A_REM);
    // a flush kills the op in E, so it must neither stall nor start the divider
    assign bus.StallReq  = ~bus.FlushE & ((state == IDLE & is_div) | state == BUSY);
    assign bus.DivStartE = ~bus.FlushE & state == IDLE & is_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            e <= '0;
        else if (bus.FlushE)
            e <= '0;
        else if (!bus.StallReq)
            e <= dec;
    end

    // IDLE is the first stall cycle, BUSY covers DIV_CYCLES-2 more, and DONE lets E advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (bus.FlushE) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (is_div) begin
                    state <= DIV_CYCLES == 2 ? DONE : BUSY;
                    cnt   <= CW'(DIV_CYCLES - 2);
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.RegWriteE   = e.reg_write;
    assign bus.MemWriteE   = e.mem_write;
    assign bus.ALUSrcE     = e.alu_src;
    assign bus.BranchE     = e.branch;
    assign bus.JumpE       = e.jump;
    assign bus.JalrE       = e.jalr;
    assign bus.ResultSrcE  = e.result_src;
    assign bus.ALUControlE = e.alu_ctrl;
    assign bus.Funct3E     = e.funct3;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed vector table plus multi-cycle divide, flush and reset sequences
module tb_decode_ctrl_stage;
    localparam logic [31:0] DIV = 32'h0220C1B3;
    localparam logic [31:0] ADD = 32'h003100B3;
    localparam int N = 19;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic [2:0]  imm;
        logic        ill;
        logic [15:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   starts0 = 0;
    vec_t v [N];
    logic [15:0] e1, e0;

    always #5 clk = ~clk;

    decode_ctrl_if #(.ALUC_W(5)) b ();
    decode_ctrl_if #(.ALUC_W(5)) b0 ();

    decode_ctrl_stage #(.M_EXT(1), .DIV_CYCLES(8), .ALUC_W(5)) dut (.clk(clk), .rst(rst), .bus(b));
    decode_ctrl_stage #(.M_EXT(0), .DIV_CYCLES(8), .ALUC_W(5)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    assign e1 = {b.RegWriteE, b.MemWriteE, b.ALUSrcE, b.BranchE, b.JumpE, b.JalrE,
                 b.ResultSrcE, b.ALUControlE, b.Funct3E};
    assign e0 = {b0.RegWriteE, b0.MemWriteE, b0.ALUSrcE, b0.BranchE, b0.JumpE, b0.JalrE,
                 b0.ResultSrcE, b0.ALUControlE, b0.Funct3E};

    always @(negedge clk) if (b0.DivStartE) starts0++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic valid);
        b.InstrD = instr;
        b.ValidD = valid;
    endtask

    initial begin
        v[0]  = '{32'h00812283, 1'b1, 3'b000, 1'b0, {6'b101000, 2'b01, 5'b00000, 3'b010}};
        v[1]  = '{32'h00512223, 1'b1, 3'b001, 1'b0, {6'b011000, 2'b00, 5'b00000, 3'b010}};
        v[2]  = '{ADD,          1'b1, 3'b000, 1'b0, {6'b100000, 2'b00, 5'b00000, 3'b000}};
        v[3]  = '{32'h403100B3, 1'b1, 3'b000, 1'b0, {6'b100000, 2'b00, 5'b00001, 3'b000}};
        v[4]  = '{32'h00208463, 1'b1, 3'b010, 1'b0, {6'b000100, 2'b00, 5'b00001, 3'b000}};
        v[5]  = '{32'h000000EF, 1'b1, 3'b011, 1'b0, {6'b100010, 2'b10, 5'b00000, 3'b000}};
        v[6]  = '{32'h00008067, 1'b1, 3'b000, 1'b0, {6'b101001, 2'b10, 5'b00000, 3'b000}};
        v[7]  = '{32'h123452B7, 1'b1, 3'b100, 1'b0, {6'b101000, 2'b00, 5'b10000, 3'b101}};
        v[8]  = '{32'h0050E093, 1'b1, 3'b000, 1'b0, {6'b101000, 2'b00, 5'b01001, 3'b110}};
        v[9]  = '{32'h00309093, 1'b1, 3'b000, 1'b0, {6'b101000, 2'b00, 5'b00100, 3'b001}};
        v[10] = '{32'h022081B3, 1'b1, 3'b000, 1'b0, {6'b100000, 2'b00, 5'b00010, 3'b000}};
        v[11] = '{32'h003140B3, 1'b1, 3'b000, 1'b0, {6'b100000, 2'b00, 5'b01010, 3'b100}};
        v[12] = '{32'h003170B3, 1'b1, 3'b000, 1'b0, {6'b100000, 2'b00, 5'b01000, 3'b111}};
        v[13] = '{32'h003150B3, 1'b1, 3'b000, 1'b0, {6'b100000, 2'b00, 5'b00101, 3'b101}};
        v[14] = '{32'h003120B3, 1'b1, 3'b000, 1'b0, {6'b100000, 2'b00, 5'b00111, 3'b010}};
        v[15] = '{32'h4030D093, 1'b1, 3'b000, 1'b1, 16'h0000};
        v[16] = '{32'h0000000F, 1'b1, 3'b000, 1'b1, 16'h0000};
        v[17] = '{32'h00813283, 1'b1, 3'b000, 1'b1, 16'h0000};
        v[18] = '{ADD,          1'b0, 3'b000, 1'b0, 16'h0000};

        rst = 1'b1;
        drive(32'h0, 1'b0);
        b.FlushE  = 1'b0;
        b0.InstrD = 32'h0;
        b0.ValidD = 1'b0;
        b0.FlushE = 1'b0;
        tick();
        tick();
        chk("reset_e", 32'(e1), 0);
        chk("reset_stall", 32'(b.StallReq), 0);
        chk("reset_start", 32'(b.DivStartE), 0);
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            drive(v[i].instr, v[i].valid);
            #1;
            chk($sformatf("v%0d_imm", i), 32'(b.ImmSrcD), 32'(v[i].imm));
            chk($sformatf("v%0d_ill", i), 32'(b.IllegalD), 32'(v[i].ill));
            tick();
            chk($sformatf("v%0d_e", i), 32'(e1), 32'(v[i].e));
            chk($sformatf("v%0d_stall", i), 32'(b.StallReq), 0);
        end

        // single divide followed by an add waiting in D
        drive(DIV, 1'b1);
        tick();
        drive(ADD, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            chk($sformatf("div_k%0d_start", k), 32'(b.DivStartE), 32'(k == 0));
            chk($sformatf("div_k%0d_stall", k), 32'(b.StallReq), 32'(k < 7));
            if (k == 7) chk("div_k7_alu", 32'(b.ALUControlE), 32'h3);
            if (k == 8) chk("div_next_e", 32'(e1), 32'(16'b100000_00_00000_000));
            tick();
        end
        drive(32'h0, 1'b0);
        tick();

        // back-to-back divides
        drive(DIV, 1'b1);
        tick();
        for (int k = 0; k <= 16; k++) begin
            chk($sformatf("b2b_k%0d_start", k), 32'(b.DivStartE), 32'(k == 0 || k == 8));
            chk($sformatf("b2b_k%0d_stall", k), 32'(b.StallReq), 32'(k < 7 || (k >= 8 && k < 15)));
            if (k == 8) drive(32'h0, 1'b0);
            if (k == 16) chk("b2b_end_e", 32'(e1), 0);
            tick();
        end

        // flush in the third BUSY cycle
        drive(DIV, 1'b1);
        tick();
        drive(32'h0, 1'b0);
        tick();
        tick();
        tick();
        chk("fl_pre_stall", 32'(b.StallReq), 1);
        b.FlushE = 1'b1;
        #1;
        chk("fl_stall", 32'(b.StallReq), 0);
        tick();
        b.FlushE = 1'b0;
        #1;
        chk("fl_e", 32'(e1), 0);
        chk("fl_state", 32'(dut.state), 0);
        chk("fl_post_stall", 32'(b.StallReq), 0);
        drive(DIV, 1'b1);
        tick();
        drive(32'h0, 1'b0);
        chk("fl_restart", 32'(b.DivStartE), 1);
        for (int k = 1; k <= 8; k++) tick();
        chk("fl_restart_done", 32'(b.StallReq), 0);

        // asynchronous reset mid-divide
        drive(DIV, 1'b1);
        tick();
        drive(32'h0, 1'b0);
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_e", 32'(e1), 0);
        chk("rst_stall", 32'(b.StallReq), 0);
        chk("rst_start", 32'(b.DivStartE), 0);
        chk("rst_state", 32'(dut.state), 0);
        #2;
        rst = 1'b0;
        drive(DIV, 1'b1);
        tick();
        drive(32'h0, 1'b0);
        chk("rst_restart", 32'(b.DivStartE), 1);
        for (int k = 1; k <= 8; k++) tick();
        chk("rst_restart_e", 32'(e1), 0);

        // M extension disabled
        b0.InstrD = DIV;
        b0.ValidD = 1'b1;
        #1;
        chk("m0_div_ill", 32'(b0.IllegalD), 1);
        tick();
        chk("m0_div_e", 32'(e0), 0);
        chk("m0_stall", 32'(b0.StallReq), 0);
        b0.InstrD = 32'h0000000F;
        #1;
        chk("m0_fence_ill", 32'(b0.IllegalD), 1);
        tick();
        b0.ValidD = 1'b0;
        tick();
        chk("m0_no_start", 32'(starts0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
